// File: rtl/hog_block_gen.sv
// hog_block_gen: assembles 2x2 HOG blocks from a raster stream of cell
// histograms, buffering one row of cells in a line RAM. Each block is
// emitted with its raster block id, its L1 bin sum and a last-of-frame flag.
module hog_block_gen #(
  parameter int unsigned N_BIN = 9,
  parameter int unsigned BIN_W = 32,
  parameter int unsigned CPR   = 40,
  parameter int unsigned CPC   = 30,
  parameter int unsigned BID_W = 13,
  parameter int unsigned SUM_W = BIN_W + $clog2(4 * N_BIN)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [N_BIN*BIN_W-1:0]   i_cell,
  input  logic                     i_sof,
  input  logic                     i_valid,
  output logic                     i_ready,
  output logic [N_BIN*BIN_W-1:0]   o_a,
  output logic [N_BIN*BIN_W-1:0]   o_b,
  output logic [N_BIN*BIN_W-1:0]   o_c,
  output logic [N_BIN*BIN_W-1:0]   o_d,
  output logic [BID_W-1:0]         o_bid,
  output logic [SUM_W-1:0]         o_sum,
  output logic                     o_last,
  output logic                     o_valid,
  input  logic                     o_ready
);

  localparam int unsigned CELL_W = N_BIN * BIN_W;
  localparam int unsigned COL_W  = (CPR > 1) ? $clog2(CPR) : 1;
  localparam int unsigned ROW_W  = (CPC > 1) ? $clog2(CPC) : 1;

  localparam logic [COL_W-1:0] COL_MAX     = COL_W'(CPR - 1);
  localparam logic [ROW_W-1:0] ROW_MAX     = ROW_W'(CPC - 1);
  localparam logic [BID_W-1:0] BLK_PER_ROW = BID_W'(CPR - 1);

  // position counters
  logic [COL_W-1:0]  col_q, col_d, col_pos_c;
  logic [ROW_W-1:0]  row_q, row_d, row_pos_c;

  // handshake / emission control
  logic              accept_c;
  logic              emit_c;
  logic              last_c;

  // line buffer and neighbour registers
  logic [CELL_W-1:0] ram_q [CPR];
  logic [CELL_W-1:0] up_rd_c;
  logic [CELL_W-1:0] prev_up_q, prev_up_d;
  logic [CELL_W-1:0] prev_cur_q, prev_cur_d;

  // block payload
  logic [BID_W-1:0]  bid_c;
  logic [SUM_W-1:0]  sum_c;

  // output stage
  logic              valid_q, valid_d;
  logic [CELL_W-1:0] a_q, a_d;
  logic [CELL_W-1:0] b_q, b_d;
  logic [CELL_W-1:0] c_q, c_d;
  logic [CELL_W-1:0] d_q, d_d;
  logic [BID_W-1:0]  bid_q, bid_d;
  logic [SUM_W-1:0]  sum_q, sum_d;
  logic              last_q, last_d;

  // Single output register without skid: accept only when it is free or draining.
  assign i_ready = !valid_q | o_ready;

  assign o_valid = valid_q;
  assign o_a     = a_q;
  assign o_b     = b_q;
  assign o_c     = c_q;
  assign o_d     = d_q;
  assign o_bid   = bid_q;
  assign o_sum   = sum_q;
  assign o_last  = last_q;

  // Effective position of the current beat; sof forces (0,0).
  always_comb begin
    accept_c  = i_valid & i_ready;
    row_pos_c = i_sof ? '0 : row_q;
    col_pos_c = i_sof ? '0 : col_q;
    emit_c    = accept_c & (row_pos_c != '0) & (col_pos_c != '0);
    last_c    = (row_pos_c == ROW_MAX) & (col_pos_c == COL_MAX);
  end

  // Raster advance with wrap at end of row and end of frame.
  always_comb begin
    col_d = col_q;
    row_d = row_q;
    if (accept_c) begin
      if (col_pos_c == COL_MAX) begin
        col_d = '0;
        row_d = (row_pos_c == ROW_MAX) ? '0 : row_pos_c + ROW_W'(1);
      end else begin
        col_d = col_pos_c + COL_W'(1);
        row_d = row_pos_c;
      end
    end
  end

  // Line RAM read of the cell directly above the current one.
  always_comb begin
    up_rd_c = ram_q[col_pos_c];
  end

  // Neighbour registers feed the left column of the next block.
  always_comb begin
    prev_up_d  = prev_up_q;
    prev_cur_d = prev_cur_q;
    if (accept_c) begin
      prev_up_d  = up_rd_c;
      prev_cur_d = i_cell;
    end
  end

  // Raster block id from the position counters; only used when row, col >= 1.
  always_comb begin
    bid_c = (BID_W'(row_pos_c) - BID_W'(1)) * BLK_PER_ROW
          + (BID_W'(col_pos_c) - BID_W'(1));
  end

  // L1 sum over all bins of the four cells, zero-extended to full width.
  always_comb begin
    sum_c = '0;
    for (int unsigned i = 0; i < N_BIN; i++) begin
      sum_c = sum_c
            + SUM_W'(prev_up_q[i*BIN_W +: BIN_W])
            + SUM_W'(up_rd_c[i*BIN_W +: BIN_W])
            + SUM_W'(prev_cur_q[i*BIN_W +: BIN_W])
            + SUM_W'(i_cell[i*BIN_W +: BIN_W]);
    end
  end

  // Output stage: load on emission, clear once drained, hold under back-pressure.
  always_comb begin
    valid_d = valid_q;
    a_d     = a_q;
    b_d     = b_q;
    c_d     = c_q;
    d_d     = d_q;
    bid_d   = bid_q;
    sum_d   = sum_q;
    last_d  = last_q;
    if (emit_c) begin
      valid_d = 1'b1;
      a_d     = prev_up_q;
      b_d     = up_rd_c;
      c_d     = prev_cur_q;
      d_d     = i_cell;
      bid_d   = bid_c;
      sum_d   = sum_c;
      last_d  = last_c;
    end else if (o_ready) begin
      valid_d = 1'b0;
    end
  end

  // Line RAM storage; contents survive reset.
  always_ff @(posedge clk) begin
    if (accept_c) begin
      ram_q[col_pos_c] <= i_cell;
    end
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      col_q      <= '0;
      row_q      <= '0;
      prev_up_q  <= '0;
      prev_cur_q <= '0;
      valid_q    <= 1'b0;
      a_q        <= '0;
      b_q        <= '0;
      c_q        <= '0;
      d_q        <= '0;
      bid_q      <= '0;
      sum_q      <= '0;
      last_q     <= 1'b0;
    end else begin
      col_q      <= col_d;
      row_q      <= row_d;
      prev_up_q  <= prev_up_d;
      prev_cur_q <= prev_cur_d;
      valid_q    <= valid_d;
      a_q        <= a_d;
      b_q        <= b_d;
      c_q        <= c_d;
      d_q        <= d_d;
      bid_q      <= bid_d;
      sum_q      <= sum_d;
      last_q     <= last_d;
    end
  end

endmodule

// File: tb/tb_hog_block_gen.sv
// Directed bench for hog_block_gen on a 4x3 cell grid with 8-bit bins.
module tb_hog_block_gen;

  localparam int unsigned N_BIN  = 9;
  localparam int unsigned BIN_W  = 8;
  localparam int unsigned CPR    = 4;
  localparam int unsigned CPC    = 3;
  localparam int unsigned BID_W  = 13;
  localparam int unsigned SUM_W  = 14;
  localparam int unsigned CELL_W = N_BIN * BIN_W;
  localparam int          MAX_CYC = 200;

  typedef struct {
    int v;
    bit sof;
  } beat_t;

  typedef struct {
    int bid;
    int a;
    int b;
    int c;
    int d;
    bit last;
  } blk_t;

  logic              clk;
  logic              rst;
  logic [CELL_W-1:0] i_cell;
  logic              i_sof;
  logic              i_valid;
  logic              i_ready;
  logic [CELL_W-1:0] o_a, o_b, o_c, o_d;
  logic [BID_W-1:0]  o_bid;
  logic [SUM_W-1:0]  o_sum;
  logic              o_last;
  logic              o_valid;
  logic              o_ready;

  int    checks;
  int    errors;
  beat_t in_q[$];
  blk_t  exp_q[$];

  hog_block_gen #(
    .N_BIN (N_BIN),
    .BIN_W (BIN_W),
    .CPR   (CPR),
    .CPC   (CPC),
    .BID_W (BID_W)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .i_cell  (i_cell),
    .i_sof   (i_sof),
    .i_valid (i_valid),
    .i_ready (i_ready),
    .o_a     (o_a),
    .o_b     (o_b),
    .o_c     (o_c),
    .o_d     (o_d),
    .o_bid   (o_bid),
    .o_sum   (o_sum),
    .o_last  (o_last),
    .o_valid (o_valid),
    .o_ready (o_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [CELL_W-1:0] cell_of(input int v);
    logic [CELL_W-1:0] r;
    r = '0;
    for (int i = 0; i < int'(N_BIN); i++) r[i*BIN_W +: BIN_W] = BIN_W'(v);
    return r;
  endfunction

  task automatic chk(input string tag, input logic [CELL_W-1:0] obs, input logic [CELL_W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_blk(input blk_t e);
    chk("valid", CELL_W'(o_valid), CELL_W'(1));
    chk("bid",   CELL_W'(o_bid), CELL_W'(e.bid));
    chk("a",     o_a, cell_of(e.a));
    chk("b",     o_b, cell_of(e.b));
    chk("c",     o_c, cell_of(e.c));
    chk("d",     o_d, cell_of(e.d));
    chk("sum",   CELL_W'(o_sum), CELL_W'(N_BIN * (e.a + e.b + e.c + e.d)));
    chk("last",  CELL_W'(o_last), CELL_W'(e.last));
  endtask

  task automatic push_frame(input int base, input int n, input bit sof_first);
    for (int k = 0; k < n; k++) in_q.push_back('{v: base + k, sof: (sof_first && k == 0)});
  endtask

  // Block j of a frame whose cell k holds base+k: top-left cell is base+(j/3)*4+j%3.
  task automatic push_golden(input int base);
    int a;
    for (int j = 0; j < 6; j++) begin
      a = base + (j / 3) * 4 + (j % 3);
      exp_q.push_back('{bid: j, a: a, b: a + 1, c: a + 4, d: a + 5, last: (j == 5)});
    end
  endtask

  // Drives in_q at full rate and checks every transferred block against exp_q.
  task automatic pump(input bit do_stall, input int first_acc);
    int   cyc;
    int   acc_cnt;
    bit   seen;
    bit   acc;
    blk_t e;
    cyc = 0; acc_cnt = 0; seen = 0;
    o_ready = 1'b1;
    while ((in_q.size() != 0 || exp_q.size() != 0 || o_valid) && cyc < MAX_CYC) begin
      if (in_q.size() != 0) begin
        i_valid = 1'b1; i_cell = cell_of(in_q[0].v); i_sof = in_q[0].sof;
      end else begin
        i_valid = 1'b0; i_cell = '0; i_sof = 1'b0;
      end
      #1;
      if (o_valid && !seen) begin
        seen = 1'b1;
        if (first_acc != 0) chk("latency_beats", CELL_W'(acc_cnt), CELL_W'(first_acc));
        if (do_stall && exp_q.size() != 0) begin
          o_ready = 1'b0;
          repeat (3) begin
            #1;
            chk("stall_iready", CELL_W'(i_ready), '0);
            check_blk(exp_q[0]);
            @(posedge clk); #1;
          end
          o_ready = 1'b1;
          #1;
        end
      end
      if (o_valid) begin
        chk("blk_expected", CELL_W'(exp_q.size() != 0), CELL_W'(1));
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          check_blk(e);
        end
      end
      acc = i_valid && i_ready;
      @(posedge clk); #1;
      if (acc) begin
        void'(in_q.pop_front());
        acc_cnt++;
      end
      cyc++;
    end
    chk("no_timeout", CELL_W'(cyc < MAX_CYC), CELL_W'(1));
    chk("all_blocks_seen", CELL_W'(exp_q.size()), '0);
    in_q.delete();
    exp_q.delete();
    i_valid = 1'b0; i_sof = 1'b0; i_cell = '0;
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_valid"}, CELL_W'(o_valid), '0);
    chk({tag, "_a"}, o_a, '0);
    chk({tag, "_b"}, o_b, '0);
    chk({tag, "_c"}, o_c, '0);
    chk({tag, "_d"}, o_d, '0);
    chk({tag, "_bid"}, CELL_W'(o_bid), '0);
    chk({tag, "_sum"}, CELL_W'(o_sum), '0);
    chk({tag, "_last"}, CELL_W'(o_last), '0);
    chk({tag, "_iready"}, CELL_W'(i_ready), CELL_W'(1));
  endtask

  initial begin
    checks = 0; errors = 0;
    rst = 1'b0; i_valid = 1'b0; i_sof = 1'b0; i_cell = '0; o_ready = 1'b1;

    // Power-on reset
    repeat (2) @(posedge clk);
    #1;
    check_zero("reset");
    rst = 1'b1;

    // Golden frame at full rate; first block one cycle after the 6th accept
    push_frame(0, 12, 1'b1);
    push_golden(0);
    pump(1'b0, 6);

    // Same frame with a 3-cycle stall on the first block
    push_frame(0, 12, 1'b1);
    push_golden(0);
    pump(1'b1, 0);

    // Two back-to-back frames, sof only on the first
    push_frame(0, 12, 1'b1);
    push_frame(20, 12, 1'b0);
    push_golden(0);
    push_golden(20);
    pump(1'b0, 0);

    // sof reasserted at k=6: only bid 0 of the partial frame, then a full frame
    push_frame(0, 6, 1'b1);
    exp_q.push_back('{bid: 0, a: 0, b: 1, c: 4, d: 5, last: 1'b0});
    push_frame(100, 12, 1'b1);
    push_golden(100);
    pump(1'b0, 0);

    // Reset while a block is pending under back-pressure
    o_ready = 1'b0;
    for (int k = 0; k < 6; k++) begin
      i_valid = 1'b1; i_sof = (k == 0); i_cell = cell_of(k);
      @(posedge clk); #1;
    end
    i_valid = 1'b0; i_sof = 1'b0; i_cell = '0;
    chk("pre_rst_valid", CELL_W'(o_valid), CELL_W'(1));
    chk("pre_rst_bid", CELL_W'(o_bid), '0);
    chk("pre_rst_iready", CELL_W'(i_ready), '0);
    rst = 1'b0;
    @(posedge clk); #1;
    check_zero("midrst");
    rst = 1'b1;

    // First frame after reset without sof starts at (0,0)
    push_frame(0, 12, 1'b0);
    push_golden(0);
    pump(1'b0, 6);

    // Saturated bins give the maximum sum 36*255
    for (int k = 0; k < 6; k++) in_q.push_back('{v: 255, sof: (k == 0)});
    exp_q.push_back('{bid: 0, a: 255, b: 255, c: 255, d: 255, last: 1'b0});
    pump(1'b0, 6);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
